// File: rtl/keypad_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Scan controller for a 4x4 matrix keypad (wb_keypad peripheral).
// The controller drives one column low at a time and waits SETTLE cycles. It
// then samples the four rows, one per cycle. Each key is debounced across
// consecutive scans. Every debounced press or release is queued as a 5-bit
// event {press, code} in a small first-word-fall-through FIFO, which the
// register front-end pops.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   enable     scanning enabled; 0 parks the scanner in IDLE and clears all
//              debounce counters (key_state and FIFO are kept)
//   col_n[3:0] column drive, active low, at most one bit low (registered)
//   row_n[3:0] raw row inputs, active low, asynchronous (pull-ups outside)
//   key_state  debounced key-down map, bit index = {col[1:0], row[1:0]}
//   key_valid  FIFO not empty
//   key_code   head event key index {col, row} (holds last value when empty)
//   key_press  head event type: 1 = press, 0 = release
//   key_pop    pop the head; ignored while the FIFO is empty
//   overflow   sticky: an event was dropped because the FIFO was full
//   clear_ovf  clears overflow (a simultaneous drop wins)
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
    parameter int SETTLE         = 8,   // >= 3, covers the row synchroniser
    parameter int DEBOUNCE_SCANS = 4,   // >= 1
    parameter int FIFO_DEPTH     = 4    // power of two, >= 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [3:0]  col_n,
    input  logic [3:0]  row_n,
    output logic [15:0] key_state,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_press,
    input  logic        key_pop,
    output logic        overflow,
    input  logic        clear_ovf
);

    localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam int SET_W = (SETTLE > 2) ? $clog2(SETTLE) : 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Row synchroniser (rows are asynchronous to clk)
    // ------------------------------------------------------------------
    logic [3:0] row_meta_reg;
    logic [3:0] row_sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_reg <= 4'hF;
            row_sync_reg <= 4'hF;
        end else begin
            row_meta_reg <= row_n;
            row_sync_reg <= row_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [1:0]       col_idx_reg, col_idx_next;
    logic [1:0]       row_idx_reg, row_idx_next;
    logic [SET_W-1:0] settle_cnt_reg, settle_cnt_next;
    logic [3:0]       col_n_reg, col_n_next;
    logic             sample_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            col_idx_reg    <= 2'd0;
            row_idx_reg    <= 2'd0;
            settle_cnt_reg <= '0;
            col_n_reg      <= 4'hF;
        end else begin
            state_reg      <= state_next;
            col_idx_reg    <= col_idx_next;
            row_idx_reg    <= row_idx_next;
            settle_cnt_reg <= settle_cnt_next;
            col_n_reg      <= col_n_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        col_idx_next    = col_idx_reg;
        row_idx_next    = row_idx_reg;
        settle_cnt_next = settle_cnt_reg;
        sample_en       = 1'b0;
        col_n_next      = 4'hF;

        if (!enable) begin
            // Dropping enable abandons whatever row evaluation was in flight.
            state_next      = ST_IDLE;
            col_idx_next    = 2'd0;
            row_idx_next    = 2'd0;
            settle_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next      = ST_DRIVE;
                    col_idx_next    = 2'd0;
                    row_idx_next    = 2'd0;
                    settle_cnt_next = '0;
                end
                ST_DRIVE: begin
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        state_next   = ST_SAMPLE;
                        row_idx_next = 2'd0;
                    end else begin
                        settle_cnt_next = settle_cnt_reg + SET_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    sample_en = 1'b1;
                    if (row_idx_reg == 2'd3) begin
                        state_next      = ST_DRIVE;
                        col_idx_next    = col_idx_reg + 2'd1;   // wraps 3 -> 0
                        row_idx_next    = 2'd0;
                        settle_cnt_next = '0;
                    end else begin
                        row_idx_next = row_idx_reg + 2'd1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        // Column drive is registered from the next state so the pins never
        // glitch and always line up with the state the FSM is in.
        if (state_next != ST_IDLE) begin
            col_n_next[col_idx_next] = 1'b0;
        end
    end

    assign col_n = col_n_reg;

    // ------------------------------------------------------------------
    // Per-key debounce
    // ------------------------------------------------------------------
    logic [3:0]  key_sel;
    logic        raw_down;
    logic [15:0] flip_vec;
    logic [15:0] key_state_reg;

    assign key_sel  = {col_idx_reg, row_idx_reg};
    assign raw_down = ~row_sync_reg[row_idx_reg];

    for (genvar gi = 0; gi < 16; gi++) begin : g_key
        logic [CNT_W-1:0] cnt_reg;
        logic             hit;
        logic             differ;

        assign hit          = sample_en && (key_sel == 4'(gi));
        assign differ       = (raw_down != key_state_reg[gi]);
        assign flip_vec[gi] = hit && differ && (cnt_reg == CNT_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (!enable) begin
                cnt_reg <= '0;
            end else if (hit) begin
                if (!differ || (cnt_reg == CNT_LAST)) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    // Only the key in its SAMPLE cycle can flip, so at most one bit of
    // flip_vec is set and at most one event is produced per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state_reg <= '0;
        end else begin
            key_state_reg <= key_state_reg ^ flip_vec;
        end
    end

    assign key_state = key_state_reg;

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic       push;
    logic [4:0] push_data;
    logic [4:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W:0] rd_ptr_reg, rd_ptr_next;
    logic       fifo_empty, fifo_full;
    logic       pop_ok, push_ok, drop;
    logic [3:0] head_code_reg, head_code_next;
    logic       head_press_reg, head_press_next;
    logic       overflow_reg;

    assign push      = |flip_vec;
    assign push_data = {raw_down, key_sel};

    // The extra pointer MSB tells full (MSBs differ) from empty (equal).
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    assign pop_ok  = key_pop && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push while full is kept.
    assign push_ok = push && (!fifo_full || pop_ok);
    assign drop    = push && fifo_full && !pop_ok;

    assign wr_ptr_next = wr_ptr_reg + (PTR_W+1)'(push_ok);
    assign rd_ptr_next = rd_ptr_reg + (PTR_W+1)'(pop_ok);

    // The head is held in registers so it keeps its last value once the FIFO
    // drains. When the entry being written becomes the new head (FIFO holds
    // exactly one entry afterwards) it is forwarded from the push data.
    always_comb begin
        head_code_next  = head_code_reg;
        head_press_next = head_press_reg;
        if (wr_ptr_next != rd_ptr_next) begin
            if (push_ok && (wr_ptr_reg[PTR_W-1:0] == rd_ptr_next[PTR_W-1:0])) begin
                head_code_next  = push_data[3:0];
                head_press_next = push_data[4];
            end else begin
                head_code_next  = fifo_mem[rd_ptr_next[PTR_W-1:0]][3:0];
                head_press_next = fifo_mem[rd_ptr_next[PTR_W-1:0]][4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            head_code_reg  <= 4'h0;
            head_press_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            head_code_reg  <= head_code_next;
            head_press_reg <= head_press_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clear_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign key_valid = !fifo_empty;
    assign key_code  = head_code_reg;
    assign key_press = head_press_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_keypad_scan_ctrl
//
// Bench for keypad_scan_ctrl with SETTLE=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4.
// A keypad model turns a 16-bit "pressed" matrix into row_n from col_n.
// The reference model works one whole scan at a time. At the end of each
// scan it applies the debounce rule to every key in index order and keeps
// the event FIFO as a queue.
// -----------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

    localparam int SETTLE_T = 4;
    localparam int DB_T     = 3;
    localparam int DEPTH_T  = 4;
    localparam int PERIOD_T = 4 * (SETTLE_T + 4);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] key_state;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_press;
    logic        key_pop = 1'b0;
    logic        overflow;
    logic        clear_ovf = 1'b0;

    logic [15:0] pressed = '0;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] m_state;
    int          m_cnt [16];
    logic [4:0]  m_q [$];
    logic        m_ovf;
    logic [4:0]  m_last;

    keypad_scan_ctrl #(
        .SETTLE         (SETTLE_T),
        .DEBOUNCE_SCANS (DB_T),
        .FIFO_DEPTH     (DEPTH_T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_state (key_state),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_press (key_press),
        .key_pop   (key_pop),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    // Passive keypad: a closed contact pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col_n[c] && pressed[c*4 + r]) row_n[r] = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Negedge offset (from a scan boundary) of the cycle in which key k is sampled.
    function automatic int key_off(input int k);
        return (SETTLE_T + 4) * (k / 4) + SETTLE_T + (k % 4);
    endfunction

    task automatic model_reset();
        m_state = '0;
        for (int k = 0; k < 16; k++) m_cnt[k] = 0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_last = 5'd0;
    endtask

    // Apply one scan of the given contact matrix to keys 0..upto-1.
    task automatic model_scan(input logic [15:0] keys, input int upto);
        for (int k = 0; k < upto; k++) begin
            if (keys[k] == m_state[k]) begin
                m_cnt[k] = 0;
            end else if (m_cnt[k] == DB_T - 1) begin
                m_state[k] = keys[k];
                m_cnt[k]   = 0;
                if (m_q.size() < DEPTH_T) m_q.push_back({keys[k], 4'(k)});
                else m_ovf = 1'b1;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [4:0] ev;
        check("key_state", 32'(key_state), 32'(m_state));
        check("key_valid", 32'(key_valid), 32'(m_q.size() != 0));
        ev = (m_q.size() != 0) ? m_q[0] : m_last;
        check("key_code", 32'(key_code), 32'(ev[3:0]));
        check("key_press", 32'(key_press), 32'(ev[4]));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Called at a negedge: checks the head and requests a pop at the next posedge.
    task automatic do_pop();
        logic [4:0] ev;
        ev = m_q[0];
        check("pop_valid", 32'(key_valid), 32'd1);
        check("pop_code", 32'(key_code), 32'(ev[3:0]));
        check("pop_press", 32'(key_press), 32'(ev[4]));
        m_last = m_q.pop_front();
        key_pop = 1'b1;
    endtask

    // Runs one full scan starting at a boundary negedge (col_n just became E).
    // npop pops at the start of the scan; pop_off / clr_off put a pop or a
    // clear_ovf into the cycle at that negedge offset (-1 = none).
    task automatic run_scan(input logic [15:0] keys, input int npop,
                            input int pop_off, input int clr_off);
        int         j;
        bit         found;
        logic [3:0] prev;
        pressed = keys;
        j = 0;
        found = 1'b0;
        while (!found && j < 200) begin
            key_pop   = 1'b0;
            clear_ovf = 1'b0;
            if ((j < npop || j == pop_off) && m_q.size() != 0) do_pop();
            if (j == clr_off) begin
                clear_ovf = 1'b1;
                m_ovf     = 1'b0;
            end
            prev = col_n;
            @(negedge clk);
            j++;
            if (prev != 4'hE && col_n == 4'hE) found = 1'b1;
        end
        key_pop   = 1'b0;
        clear_ovf = 1'b0;
        check("scan_boundary", 32'(found), 32'd1);
        check("scan_period", 32'(j), 32'(PERIOD_T));
        model_scan(keys, 16);
        check_outputs();
    endtask

    task automatic run_scans(input logic [15:0] keys, input int n);
        for (int i = 0; i < n; i++) run_scan(keys, 0, -1, -1);
    endtask

    task automatic drain(input logic [15:0] keys);
        run_scan(keys, 4, -1, -1);
    endtask

    // Scan in which enable drops during the SAMPLE cycle of key k.
    task automatic run_abort(input logic [15:0] keys, input int k);
        pressed = keys;
        repeat (key_off(k)) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_col_n", 32'(col_n), 32'hF);
        model_scan(keys, k);
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        check_outputs();
        enable = 1'b1;
        @(negedge clk);
        check("reenable_col_n", 32'(col_n), 32'hE);
    endtask

    initial begin
        logic [3:0]  exp_col;
        logic [15:0] rkeys;
        logic [15:0] flip;

        model_reset();

        // 1. reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_reset_col_n", 32'(col_n), 32'hE);
        #2 rst_n = 1'b0;
        #1;
        check("rst_col_n", 32'(col_n), 32'hF);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_state", 32'(key_state), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_key_press", 32'(key_press), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_col_n", 32'(col_n), 32'hF);
        enable = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            exp_col = 4'hF;
            exp_col[((j - 1) / 8) % 4] = 1'b0;
            check("scan_col_n", 32'(col_n), 32'(exp_col));
        end
        @(negedge clk);
        check("second_scan_col_n", 32'(col_n), 32'hE);

        // 2. single press / release of row1/col2 (key 9)
        run_scans(16'h0200, 4);
        check("s2_state", 32'(key_state), 32'h0200);
        check("s2_code", 32'(key_code), 32'h9);
        check("s2_press", 32'(key_press), 32'd1);
        run_scan(16'h0000, 1, -1, -1);
        check("s2_empty_hold_code", 32'(key_code), 32'h9);
        run_scans(16'h0000, 3);
        check("s2_rel_state", 32'(key_state), 32'h0);
        check("s2_rel_code", 32'(key_code), 32'h9);
        check("s2_rel_press", 32'(key_press), 32'd0);
        drain(16'h0000);

        // 3. glitch rejection on row3/col0 (key 3)
        run_scans(16'h0008, 2);
        run_scans(16'h0000, 3);
        check("s3_glitch_state", 32'(key_state), 32'h0);
        check("s3_glitch_valid", 32'(key_valid), 32'd0);
        run_scans(16'h0008, 2);
        run_scans(16'h0000, 1);
        run_scans(16'h0008, 2);
        check("s3_bounce_state", 32'(key_state), 32'h0);
        run_scans(16'h0008, 1);
        check("s3_bounce_done", 32'(key_state), 32'h0008);
        run_scans(16'h0000, 3);
        drain(16'h0000);

        // 4. same-column chord: col1 rows 0 and 3 (keys 4 and 7)
        run_scans(16'h0090, 3);
        check("s4_first_code", 32'(key_code), 32'h4);
        run_scan(16'h0090, 1, -1, -1);
        check("s4_second_code", 32'(key_code), 32'h7);
        check("s4_second_press", 32'(key_press), 32'd1);
        run_scans(16'h0000, 3);
        drain(16'h0000);
        drain(16'h0000);

        // 5. overflow: five presses (keys 0,1,2,5,10), key 10 dropped
        run_scans(16'h0427, 3);
        check("s5_ovf", 32'(overflow), 32'd1);
        check("s5_state", 32'(key_state), 32'h0427);
        check("s5_head", 32'(key_code), 32'h0);
        run_scan(16'h0427, 4, -1, 10);
        check("s5_ovf_cleared", 32'(overflow), 32'd0);
        run_scans(16'h0400, 3);          // four release events: FIFO full
        run_scans(16'h8400, 2);
        run_scan(16'h8400, 0, key_off(15), -1);   // pop on the push edge
        check("s5_pop_push_ovf", 32'(overflow), 32'd0);
        check("s5_pop_push_valid", 32'(key_valid), 32'd1);
        run_scans(16'h8000, 2);
        run_scan(16'h8000, 0, -1, key_off(10));   // drop and clear together
        check("s5_set_wins", 32'(overflow), 32'd1);
        check("s5_state_after_drop", 32'(key_state), 32'h8000);
        drain(16'h8000);
        run_scans(16'h0000, 3);
        drain(16'h0000);
        run_scan(16'h0000, 0, -1, 0);

        // 6. enable dropped while key 6 (col1,row2) sits at cnt=2
        run_scans(16'h0040, 2);
        run_abort(16'h0040, 6);
        run_scans(16'h0040, 2);
        check("s6_not_yet", 32'(key_state), 32'h0);
        run_scans(16'h0040, 1);
        check("s6_fresh_count", 32'(key_state), 32'h0040);
        run_scans(16'h0000, 3);
        drain(16'h0000);

        // randomized scans against the model
        rkeys = '0;
        for (int s = 0; s < 40; s++) begin
            flip = '0;
            for (int k = 0; k < 16; k++) flip[k] = ($urandom_range(0, 4) == 0);
            rkeys = rkeys ^ flip;
            run_scan(rkeys, $urandom_range(0, 3), -1,
                     ($urandom_range(0, 3) == 0) ? 0 : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
